// File: rtl/melody_sequencer.sv
// Multi-song melody player: steps through note RAM entries {end, rest, dur, tone}
// and drives a tone code plus sound-enable towards the tone-to-frequency divider.
module melody_sequencer #(
    parameter int TONE_W     = 4,
    parameter int DUR_W      = 3,
    parameter int NUM_SONGS  = 4,
    parameter int SONG_DEPTH = 32,
    parameter int ARTIC      = 1
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    beat_tick,
    input  logic                                    start,
    input  logic [$clog2(NUM_SONGS)-1:0]            song_sel,
    input  logic                                    loop,
    input  logic                                    stop,
    input  logic                                    pause,
    input  logic                                    wr_en,
    input  logic [$clog2(NUM_SONGS*SONG_DEPTH)-1:0] wr_addr,
    input  logic [TONE_W+DUR_W+1:0]                 wr_data,
    output logic [TONE_W-1:0]                       tone,
    output logic                                    enable_out,
    output logic                                    busy,
    output logic                                    done,
    output logic [$clog2(SONG_DEPTH)-1:0]           note_idx
);

    localparam int SONG_W = $clog2(NUM_SONGS);
    localparam int IDX_W  = $clog2(SONG_DEPTH);
    localparam int ADDR_W = SONG_W + IDX_W;
    localparam int DATA_W = TONE_W + DUR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_PLAY   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SONG_W-1:0]   song_q, song_d;
    logic                loop_q, loop_d;
    logic [DUR_W-1:0]    rem_q, rem_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic                rest_q, rest_d;
    logic [TONE_W-1:0]   tone_q, tone_d;
    logic                enable_q, enable_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   mem [NUM_SONGS*SONG_DEPTH];
    logic [DATA_W-1:0]   rd_data_q;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic                rd_end_s;
    logic                rd_rest_s;
    logic [DUR_W-1:0]    rd_dur_s;
    logic [TONE_W-1:0]   rd_tone_s;

    // The last beat of a multi-beat note is left silent so repeated tones separate.
    function automatic logic artic_beat(input logic [DUR_W-1:0] dur, input logic [DUR_W-1:0] rem);
        return (ARTIC != 0) && (dur >= DUR_W'(2)) && (rem == DUR_W'(1));
    endfunction

    assign rd_addr_s = {song_q, idx_q};
    assign rd_tone_s = rd_data_q[TONE_W-1:0];
    assign rd_dur_s  = rd_data_q[TONE_W+DUR_W-1:TONE_W];
    assign rd_rest_s = rd_data_q[TONE_W+DUR_W];
    assign rd_end_s  = rd_data_q[TONE_W+DUR_W+1];

    // Note RAM: read-first, never reset.
    always_ff @(posedge clk) begin
        rd_data_q <= mem[rd_addr_s];
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            song_q   <= '0;
            loop_q   <= 1'b0;
            rem_q    <= '0;
            dur_q    <= '0;
            rest_q   <= 1'b0;
            tone_q   <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            song_q   <= song_d;
            loop_q   <= loop_d;
            rem_q    <= rem_d;
            dur_q    <= dur_d;
            rest_q   <= rest_d;
            tone_q   <= tone_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state and sequencing datapath; stop overrides every transition.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        song_d  = song_q;
        loop_d  = loop_q;
        rem_d   = rem_q;
        dur_d   = dur_q;
        rest_d  = rest_q;
        tone_d  = tone_q;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        song_d  = song_sel;
                        loop_d  = loop;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    if (rd_end_s) begin
                        // Looping is refused on an end flag at index 0 to avoid an empty spin.
                        if (loop_q && (idx_q != IDX_W'(0))) begin
                            idx_d   = '0;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        if (!rd_rest_s) begin
                            tone_d = rd_tone_s;
                        end else begin
                            tone_d = tone_q;
                        end
                        dur_d   = rd_dur_s;
                        rest_d  = rd_rest_s;
                        rem_d   = (rd_dur_s == DUR_W'(0)) ? DUR_W'(1) : rd_dur_s;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (beat_tick && !pause) begin
                        if (rem_q == DUR_W'(1)) begin
                            if (idx_q == IDX_W'(SONG_DEPTH-1)) begin
                                if (loop_q) begin
                                    idx_d   = '0;
                                    state_d = S_FETCH;
                                end else begin
                                    state_d = S_DONE;
                                end
                            end else begin
                                idx_d   = idx_q + IDX_W'(1);
                                state_d = S_FETCH;
                            end
                        end else begin
                            rem_d = rem_q - DUR_W'(1);
                        end
                    end else begin
                        state_d = S_PLAY;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs are registered from the upcoming state so they align with it.
    always_comb begin
        busy_d   = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_PLAY);
        done_d   = (state_d == S_DONE);
        enable_d = (state_d == S_PLAY) && !rest_d && !pause && !artic_beat(dur_d, rem_d);
    end

    assign tone       = tone_q;
    assign enable_out = enable_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign note_idx   = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer: a cycle table for a basic song plus
// hand-written sequences for rests, looping, stop, pause, full-depth songs and reset.
module tb_melody_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       beat_tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] song_sel = 2'd0;
    logic       loop = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       wr_en = 1'b0;
    logic [6:0] wr_addr = 7'd0;
    logic [8:0] wr_data = 9'd0;
    logic [3:0] tone;
    logic       enable_out;
    logic       busy;
    logic       done;
    logic [4:0] note_idx;

    int nvec = 0;
    int nmis = 0;

    melody_sequencer dut (
        .clk(clk), .reset(reset), .beat_tick(beat_tick), .start(start),
        .song_sel(song_sel), .loop(loop), .stop(stop), .pause(pause),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tone(tone), .enable_out(enable_out), .busy(busy), .done(done),
        .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [1:0] sng;
        logic       lp;
        logic       tk;
        logic       ps;
        logic [3:0] e_tone;
        logic       e_en;
        logic       e_busy;
        logic       e_done;
        logic [4:0] e_idx;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clk1(input logic tk);
        beat_tick = tk;
        @(posedge clk);
        #1;
        beat_tick = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wn(input int sg, input int ix, input logic e, input logic r, input int dr, input int tn);
        wr_addr = 7'(sg * 32 + ix);
        wr_data = {e, r, 3'(dr), 4'(tn)};
        wr_en = 1'b1;
        clk1(1'b0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[1]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[2]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, 5'd0};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 5'd0};
        tbl[5]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 5'd1};
        tbl[6]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd4, 1'b0, 1'b1, 1'b0, 5'd1};
        tbl[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 5'd1};
        tbl[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 5'd1};
        tbl[9]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 5'd1};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 5'd2};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 1'b0, 5'd2};
        tbl[12] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 5'd2};
        tbl[13] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 5'd3};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b1, 1'b0, 5'd3};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b1, 5'd3};
        tbl[16] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 5'd3};
        tbl[17] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0, 5'd3};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_tone", 32'(tone), 32'd0);
        chk("rst_en", 32'(enable_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_idx", 32'(note_idx), 32'd0);

        wn(1, 0, 1'b0, 1'b0, 2, 4);
        wn(1, 1, 1'b0, 1'b0, 1, 1);
        wn(1, 2, 1'b0, 1'b0, 1, 2);
        wn(1, 3, 1'b1, 1'b0, 0, 0);
        wn(2, 0, 1'b0, 1'b0, 1, 5);
        wn(2, 1, 1'b0, 1'b1, 2, 9);
        wn(2, 2, 1'b0, 1'b0, 1, 6);
        wn(2, 3, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 3; i++) wn(3, i, 1'b0, 1'b0, 1, 7 + i);
        wn(3, 3, 1'b1, 1'b0, 0, 0);
        wn(0, 0, 1'b1, 1'b0, 1, 0);

        // Song 1 walked cycle by cycle: articulation, uncounted first tick, pause, done, ignored start.
        for (int i = 0; i < 18; i++) begin
            start = tbl[i].st;
            song_sel = tbl[i].sng;
            loop = tbl[i].lp;
            pause = tbl[i].ps;
            clk1(tbl[i].tk);
            pause = 1'b0;
            chk($sformatf("v%0d_tone", i), 32'(tone), 32'(tbl[i].e_tone));
            chk($sformatf("v%0d_en", i), 32'(enable_out), 32'(tbl[i].e_en));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d_idx", i), 32'(note_idx), 32'(tbl[i].e_idx));
        end

        // Rest entry lasts two ticks, silent, tone kept from the previous note.
        song_sel = 2'd2; loop = 1'b0; start = 1'b1;
        clk1(1'b0); clk1(1'b0); clk1(1'b0);
        chk("rest_n0_tone", 32'(tone), 32'd5);
        chk("rest_n0_en", 32'(enable_out), 32'd1);
        clk1(1'b1); clk1(1'b0); clk1(1'b0);
        chk("rest_tone", 32'(tone), 32'd5);
        chk("rest_en", 32'(enable_out), 32'd0);
        chk("rest_idx", 32'(note_idx), 32'd1);
        clk1(1'b1);
        chk("rest_en_b2", 32'(enable_out), 32'd0);
        chk("rest_idx_b2", 32'(note_idx), 32'd1);
        clk1(1'b1);
        chk("rest_end_idx", 32'(note_idx), 32'd2);
        clk1(1'b0); clk1(1'b0);
        chk("rest_n2_tone", 32'(tone), 32'd6);
        chk("rest_n2_en", 32'(enable_out), 32'd1);
        clk1(1'b1); clk1(1'b0); clk1(1'b0);
        chk("rest_done", 32'(done), 32'd1);
        clk1(1'b0);

        // Looping song with a live rewrite of entry 1, then stop with a coincident tick.
        song_sel = 2'd3; loop = 1'b1; start = 1'b1;
        clk1(1'b0);
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 3; n++) begin
                clk1(1'b0); clk1(1'b0);
                chk($sformatf("loop_p%0d_n%0d_tone", p, n), 32'(tone),
                    (p == 2 && n == 1) ? 32'd10 : 32'(7 + n));
                chk($sformatf("loop_p%0d_n%0d_idx", p, n), 32'(note_idx), 32'(n));
                chk($sformatf("loop_p%0d_n%0d_en", p, n), 32'(enable_out), 32'd1);
                if (p == 1 && n == 1) begin
                    wr_addr = 7'(3 * 32 + 1);
                    wr_data = {1'b0, 1'b0, 3'd1, 4'd10};
                    wr_en = 1'b1;
                end
                clk1(1'b1);
                chk("loop_no_done", 32'(done), 32'd0);
            end
            clk1(1'b0);
            chk("loop_no_done", 32'(done), 32'd0);
            clk1(1'b0);
            chk($sformatf("loop_wrap_idx_p%0d", p), 32'(note_idx), 32'd0);
            chk("loop_wrap_busy", 32'(busy), 32'd1);
            chk("loop_no_done", 32'(done), 32'd0);
        end
        clk1(1'b0); clk1(1'b0);
        chk("stop_pre_en", 32'(enable_out), 32'd1);
        stop = 1'b1;
        clk1(1'b1);
        chk("stop_en", 32'(enable_out), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            clk1(1'b0);
            chk("stop_no_done", 32'(done), 32'd0);
            chk("stop_idle_busy", 32'(busy), 32'd0);
        end

        // End flag at index 0 with loop requested ends the song immediately.
        song_sel = 2'd0; loop = 1'b1; start = 1'b1;
        clk1(1'b0);
        chk("e0_busy1", 32'(busy), 32'd1);
        chk("e0_done1", 32'(done), 32'd0);
        clk1(1'b0);
        chk("e0_busy2", 32'(busy), 32'd1);
        chk("e0_done2", 32'(done), 32'd0);
        clk1(1'b0);
        chk("e0_done3", 32'(done), 32'd1);
        chk("e0_busy3", 32'(busy), 32'd0);
        clk1(1'b0);
        chk("e0_done4", 32'(done), 32'd0);

        // Full 32-entry song with a 5-tick pause in the middle of note 10.
        for (int i = 0; i < 32; i++) wn(0, i, 1'b0, 1'b0, 1, i % 16);
        song_sel = 2'd0; loop = 1'b0; start = 1'b1;
        clk1(1'b0);
        for (int n = 0; n < 32; n++) begin
            clk1(1'b0); clk1(1'b0);
            chk($sformatf("full_n%0d_idx", n), 32'(note_idx), 32'(n));
            chk($sformatf("full_n%0d_tone", n), 32'(tone), 32'(n % 16));
            chk($sformatf("full_n%0d_en", n), 32'(enable_out), 32'd1);
            if (n == 10) begin
                pause = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    clk1(1'b1);
                    chk("pause_en", 32'(enable_out), 32'd0);
                    chk("pause_idx", 32'(note_idx), 32'd10);
                    chk("pause_busy", 32'(busy), 32'd1);
                end
                pause = 1'b0;
                clk1(1'b0);
                chk("unpause_en", 32'(enable_out), 32'd1);
                chk("unpause_idx", 32'(note_idx), 32'd10);
            end
            clk1(1'b1);
            if (n < 31) begin
                chk("full_next_idx", 32'(note_idx), 32'(n + 1));
                chk("full_no_done", 32'(done), 32'd0);
            end else begin
                chk("full_done", 32'(done), 32'd1);
                chk("full_done_busy", 32'(busy), 32'd0);
                chk("full_done_idx", 32'(note_idx), 32'd31);
            end
        end
        clk1(1'b0);
        chk("full_done_clr", 32'(done), 32'd0);

        // Asynchronous reset mid-note, then replay from retained RAM.
        song_sel = 2'd1; loop = 1'b0; start = 1'b1;
        clk1(1'b0); clk1(1'b0); clk1(1'b0);
        chk("pre_rst_en", 32'(enable_out), 32'd1);
        chk("pre_rst_tone", 32'(tone), 32'd4);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tone", 32'(tone), 32'd0);
        chk("arst_en", 32'(enable_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_idx", 32'(note_idx), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        song_sel = 2'd1; start = 1'b1;
        clk1(1'b0); clk1(1'b0); clk1(1'b0);
        chk("replay_tone", 32'(tone), 32'd4);
        chk("replay_en", 32'(enable_out), 32'd1);
        chk("replay_idx", 32'(note_idx), 32'd0);
        clk1(1'b1);
        chk("replay_artic_en", 32'(enable_out), 32'd0);
        stop = 1'b1;
        clk1(1'b0);
        chk("replay_stop_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
